// File: rtl/cache_pkg.sv
// Shared cache fill definitions: block geometry, latency default and
// state encoding used by the caches, the arbiter and the fill controller.
package cache_pkg;

   localparam int WORDS_PER_BLOCK = 8;
   localparam int MEM_LATENCY     = 4;
   localparam int OFFSET_W        = $clog2(WORDS_PER_BLOCK);
   localparam int CNT_W           = OFFSET_W + 1;

   localparam int WORD_LSB  = 1;
   localparam int WORD_MSB  = 3;
   localparam int BLOCK_LSB = 4;
   localparam int BLOCK_MSB = 15;

   localparam logic ST_IDLE_ENC = 1'b0;
   localparam logic ST_FILL_ENC = 1'b1;

   typedef enum logic {
      ST_IDLE = ST_IDLE_ENC,
      ST_FILL = ST_FILL_ENC
   } fill_state_e;

endpackage

// File: rtl/fill_word_counter.sv
// Word counter for block fills: clear, enable and a flag at the
// terminal count so a fill can tell "all words done" from offset 0.
module fill_word_counter #(
   parameter int TERMINAL = cache_pkg::WORDS_PER_BLOCK
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr_i,
   input  logic                       en_i,
   output logic [cache_pkg::CNT_W-1:0] cnt_o,
   output logic                       done_o
);
   import cache_pkg::*;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign done_o = (cnt_q == CNT_W'(TERMINAL));
   assign cnt_o  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: streams one read per cycle for a block
// and steers returned words into the data array, tag on the last word.
module cache_fill_fsm #(
   parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
   parameter int MEM_LATENCY     = cache_pkg::MEM_LATENCY
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        miss_detected,
   input  logic [15:0] miss_address,
   input  logic        memory_data_valid,
   input  logic [15:0] memory_data,
   output logic        fsm_busy,
   output logic        memory_read,
   output logic [15:0] memory_address,
   output logic        write_data_array,
   output logic [2:0]  data_word_offset,
   output logic [15:0] cache_data_out,
   output logic        write_tag_array,
   output logic [15:0] block_address
);
   import cache_pkg::*;

   if (WORDS_PER_BLOCK != (1 << OFFSET_W)) begin : g_bad_wpb
      $error("WORDS_PER_BLOCK must match the 16-byte block layout");
   end
   if (MEM_LATENCY < 1) begin : g_bad_lat
      $error("MEM_LATENCY must be at least 1");
   end

   fill_state_e      state_q;
   logic [15:0]      base_q;
   logic [CNT_W-1:0] iss_cnt, rx_cnt;
   logic             iss_done, rx_done;
   logic             is_fill, start, iss_en, rx_en, rx_last;
   logic             unused_addr_lsb;

   assign unused_addr_lsb = ^miss_address[BLOCK_LSB-1:0];

   assign is_fill = (state_q == ST_FILL);
   assign start   = !is_fill && miss_detected;
   assign iss_en  = is_fill && !iss_done;
   assign rx_en   = is_fill && memory_data_valid && !rx_done;
   assign rx_last = rx_en && (rx_cnt == CNT_W'(WORDS_PER_BLOCK - 1));

   fill_word_counter #(.TERMINAL(WORDS_PER_BLOCK)) u_issue_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (start),
      .en_i   (iss_en),
      .cnt_o  (iss_cnt),
      .done_o (iss_done)
   );

   fill_word_counter #(.TERMINAL(WORDS_PER_BLOCK)) u_recv_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (start),
      .en_i   (rx_en),
      .cnt_o  (rx_cnt),
      .done_o (rx_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (miss_detected) begin
                  state_q <= ST_FILL;
                  base_q  <= {miss_address[BLOCK_MSB:BLOCK_LSB],
                              {BLOCK_LSB{1'b0}}};
               end
            end
            ST_FILL: begin
               if (rx_last)
                  state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Requests walk the block by word; the offset wraps once issue saturates
   assign fsm_busy         = is_fill || miss_detected;
   assign memory_read      = is_fill && (iss_cnt < CNT_W'(WORDS_PER_BLOCK));
   assign memory_address   = is_fill ?
                             {base_q[BLOCK_MSB:BLOCK_LSB],
                              iss_cnt[OFFSET_W-1:0], 1'b0} : '0;
   assign write_data_array = rx_en;
   assign data_word_offset = rx_en ? rx_cnt[OFFSET_W-1:0] : '0;
   assign cache_data_out   = memory_data;
   assign write_tag_array  = rx_last;
   assign block_address    = is_fill ? base_q : '0;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a 4-cycle pipelined memory model.
// Expected timing is derived from the miss cycle, not from the model.
module tb_cache_fill_fsm;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        miss_detected = 1'b0;
   logic [15:0] miss_address = '0;
   logic        memory_data_valid = 1'b0;
   logic [15:0] memory_data = '0;
   logic        fsm_busy, memory_read, write_data_array, write_tag_array;
   logic [15:0] memory_address, cache_data_out, block_address;
   logic [2:0]  data_word_offset;

   int vectors = 0;
   int miscompares = 0;
   int now = 0;
   int gap_lo = -1;
   int gap_hi = -2;
   logic [15:0] q_addr[$];
   int          q_rdy[$];

   always #5 clk = ~clk;

   cache_fill_fsm dut (
      .clk               (clk),
      .rst               (rst),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .memory_data_valid (memory_data_valid),
      .memory_data       (memory_data),
      .fsm_busy          (fsm_busy),
      .memory_read       (memory_read),
      .memory_address    (memory_address),
      .write_data_array  (write_data_array),
      .data_word_offset  (data_word_offset),
      .cache_data_out    (cache_data_out),
      .write_tag_array   (write_tag_array),
      .block_address     (block_address)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s t=%0d observed=%h expected=%h", tag, now, obs, exp);
      end
   endtask

   // One clock: drive inputs, serve the memory pipe, record new requests
   task automatic cyc_step(input logic m, input logic [15:0] ma,
                           input logic r, input logic fv);
      @(posedge clk);
      #1;
      now++;
      rst = r;
      miss_detected = m;
      miss_address = ma;
      memory_data_valid = 1'b0;
      memory_data = 16'h0F0F ^ 16'(now);
      if (fv) begin
         memory_data_valid = 1'b1;
         memory_data = 16'hBEEF;
      end else if (q_rdy.size() > 0 && q_rdy[0] <= now &&
                   !(now >= gap_lo && now <= gap_hi)) begin
         memory_data_valid = 1'b1;
         memory_data = q_addr[0] ^ 16'hC3C3;
         void'(q_rdy.pop_front());
         void'(q_addr.pop_front());
      end
      #1;
      if (memory_read) begin
         q_addr.push_back(memory_address);
         q_rdy.push_back(now + 4);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, fsm_busy, 0);
      chk({tag, "_read"}, memory_read, 0);
      chk({tag, "_maddr"}, memory_address, 0);
      chk({tag, "_wda"}, write_data_array, 0);
      chk({tag, "_off"}, data_word_offset, 0);
      chk({tag, "_tag"}, write_tag_array, 0);
      chk({tag, "_baddr"}, block_address, 0);
   endtask

   task automatic run_fill(input logic [15:0] ma, input logic chained,
                           input logic gap, input logic intr, input int rst_k,
                           input logic nxt, input logic [15:0] nma);
      logic [15:0] base;
      int e, t0, kend, j_exp;
      logic w_exp, m;
      logic [15:0] a;
      base = {ma[15:4], 4'h0};
      e = gap ? 15 : 12;
      if (!chained) cyc_step(1'b1, ma, 1'b0, 1'b0);
      t0 = now;
      gap_lo = gap ? t0 + 9 : -1;
      gap_hi = gap ? t0 + 11 : -2;
      chk("c0_busy", fsm_busy, 1);
      chk("c0_read", memory_read, 0);
      chk("c0_wda", write_data_array, 0);
      kend = (rst_k > 0) ? rst_k : e + 1;
      for (int k = 1; k <= kend; k++) begin
         m = 1'b0;
         a = '0;
         if (intr && (k == 3 || k == 10)) begin
            m = 1'b1;
            a = 16'hABCD;
         end
         if (k == e + 1 && nxt) begin
            m = 1'b1;
            a = nma;
         end
         cyc_step(m, a, k == rst_k, 1'b0);
         if (k == rst_k) begin
            chk_zero("rst");
            chk("rst_data", cache_data_out, memory_data);
         end else begin
            w_exp = 1'b0;
            j_exp = 0;
            for (int j = 0; j < 8; j++)
               if (5 + j + ((gap && j >= 4) ? 3 : 0) == k) begin
                  w_exp = 1'b1;
                  j_exp = j;
               end
            chk("busy", fsm_busy, (k <= e) || (k == e + 1 && nxt));
            chk("read", memory_read, (k >= 1 && k <= 8));
            if (k <= 8)
               chk("maddr", memory_address, 16'(base + 2 * (k - 1)));
            chk("wda", write_data_array, w_exp);
            if (w_exp) begin
               chk("off", data_word_offset, j_exp);
               chk("data", cache_data_out, 16'(base + 2 * j_exp) ^ 16'hC3C3);
            end
            chk("tag", write_tag_array, k == e);
            if (k <= e) chk("baddr", block_address, base);
         end
      end
   endtask

   initial begin
      // Reset state
      cyc_step(1'b0, 16'h0, 1'b1, 1'b0);
      chk_zero("init");
      chk("init_data", cache_data_out, memory_data);
      cyc_step(1'b0, 16'h0, 1'b0, 1'b0);
      chk_zero("idle");

      // Spurious valid in IDLE
      for (int i = 0; i < 2; i++) begin
         cyc_step(1'b0, 16'h0, 1'b0, 1'b1);
         chk("spur_busy", fsm_busy, 0);
         chk("spur_wda", write_data_array, 0);
         chk("spur_tag", write_tag_array, 0);
      end

      // Single miss chained straight into a second miss
      run_fill(16'h1236, 1'b0, 1'b0, 1'b0, 0, 1'b1, 16'hFFF0);
      run_fill(16'hFFF0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'h0);

      // Gapped returns with misses arriving mid-fill
      cyc_step(1'b0, 16'h0, 1'b0, 1'b0);
      run_fill(16'h456A, 1'b0, 1'b1, 1'b1, 0, 1'b0, 16'h0);

      // Reset mid-fill, then in-flight returns must be dropped
      cyc_step(1'b0, 16'h0, 1'b0, 1'b0);
      run_fill(16'h7770, 1'b0, 1'b0, 1'b0, 7, 1'b0, 16'h0);
      for (int i = 0; i < 6; i++) begin
         cyc_step(1'b0, 16'h0, 1'b0, 1'b0);
         chk("drain_busy", fsm_busy, 0);
         chk("drain_wda", write_data_array, 0);
         chk("drain_tag", write_tag_array, 0);
      end
      chk("drain_empty", q_rdy.size(), 0);

      // Fresh fill after reset starts its counts from zero
      run_fill(16'h0102, 1'b0, 1'b0, 1'b0, 0, 1'b0, 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller between the pipeline's instruction/data caches and the shared multi-cycle main memory. On a cache miss it stalls the pipeline, issues one read per cycle for every word of the 16-byte block to a pipelined memory, and steers each returned word into the cache data array. It writes the tag once the last word lands. One instance serves each cache. The instances are arbitrated outside this block.

## Interface
Parameters:
- WORDS_PER_BLOCK, 8, words per cache block (power of two); fixes offset width at log2 = 3
- MEM_LATENCY, 4, cycles from a sampled read request to its memory_data_valid

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- miss_detected  input  1  cache lookup missed this cycle
- miss_address  input  16  byte address of the missing access
- memory_data_valid  input  1  memory_data holds a returned word this cycle
- memory_data  input  16  returned word
- fsm_busy  output  1  stall pipeline; fill in progress
- memory_read  output  1  read request to memory this cycle
- memory_address  output  16  word-aligned address of the request
- write_data_array  output  1  write cache_data_out into data array at data_word_offset
- data_word_offset  output  3  word slot within the block being written
- cache_data_out  output  16  word to write (memory_data passthrough)
- write_tag_array  output  1  write tag/valid for the block at block_address
- block_address  output  16  latched {miss_address[15:4], 4'b0}

## Operation
- States: IDLE, FILL.
- IDLE:
  - fsm_busy = miss_detected (combinational).
  - On miss_detected, latch block base, clear issue_cnt and recv_cnt, go to FILL.
  - All other outputs 0. memory_data_valid is ignored.
- FILL, issue side:
  - memory_read = 1 while issue_cnt < WORDS_PER_BLOCK.
  - memory_address = {base[15:4], issue_cnt[2:0], 1'b0}.
  - issue_cnt increments each FILL cycle, saturating at 8.
- FILL, receive side:
  - On memory_data_valid, assert write_data_array with data_word_offset = recv_cnt[2:0] and cache_data_out = memory_data; recv_cnt then increments.
  - On the valid with recv_cnt == 7, also assert write_tag_array, then go to IDLE.
- FILL: fsm_busy = 1 throughout. miss_detected and miss_address are ignored.
- Offsets wrap naturally in 3 bits. The counters are 4 bits so that the terminal value 8 is distinguishable.
- Asynchronous reset:
  - Forces IDLE and clears counters and latched base.
  - Memory returns still in flight are discarded, because IDLE ignores valid.
  - Reset mid-fill leaves the tag unwritten, so the block stays invalid.
- Reset values:
  - fsm_busy, memory_read, write_data_array and write_tag_array are 0.
  - memory_address, data_word_offset and block_address are 0.
  - cache_data_out follows memory_data.

## Timing
- Let cycle 0 be the cycle in which miss_detected is high in IDLE. fsm_busy is high in cycle 0.
- Requests are issued in cycles 1-8, with offsets 0-7.
- With MEM_LATENCY = 4, returns arrive in cycles 5-12.
- write_tag_array is asserted in cycle 12, and fsm_busy drops in cycle 13.
- Total stall per miss = 13 cycles.
- The block tolerates gaps in memory_data_valid: receipt is counted, not timed. The fill still ends only after the 8th valid.
- The earliest a new miss can be accepted is the cycle after the return to IDLE.

## Structure
- Shared package cache_pkg holds the following, for use by caches and the arbiter:
  - the WORDS_PER_BLOCK and MEM_LATENCY defaults
  - the offset width
  - block-offset bit positions (address [3:1] word, [15:4] block)
  - the state encoding localparams
- Sub-module fill_word_counter: 4-bit counter with clear, enable and a terminal flag at WORDS_PER_BLOCK. It is instantiated twice, once for issue and once for receive.
- The rest (FSM and address/offset muxing) lives in cache_fill_fsm.

## Test plan
- Single miss:
  - Stimulus: miss_address = 0x1236 in cycle 0; memory model with 4-cycle latency.
  - Required response: memory_address = 0x1230, 0x1232 … 0x123E in cycles 1-8; write_data_array in cycles 5-12 with offsets 0-7; write_tag_array only in cycle 12, with block_address = 0x1230; fsm_busy high in cycles 0-12.
- Gapped returns:
  - Stimulus: the memory model withholds valid for 3 cycles after the 4th word.
  - Required response: offsets stay in order 0-7, the tag is written with the 8th word, and fsm_busy is held 3 extra cycles.
- Miss ignored during FILL:
  - Stimulus: miss_detected pulses with address 0xABCD mid-fill.
  - Required response: no change to addresses or base; the fill completes unaffected.
- Reset mid-fill:
  - Stimulus: rst asserted in cycle 7.
  - Required response: all outputs 0 immediately; the 3+ pending returns produce no write_data_array or write_tag_array.
- Back-to-back misses:
  - Stimulus: a second miss to 0xFFF0 asserted in the cycle after fsm_busy drops.
  - Required response: addresses 0xFFF0-0xFFFE are issued; the offsets do not reuse counts left from the previous fill.
- Spurious valid:
  - Stimulus: memory_data_valid asserted in IDLE.
  - Required response: no array writes, and fsm_busy stays 0.
